pc_sequencer: RTL and testbench

Program-counter sequencer at the fetch end of the MZNM pipeline. It consumes the `pcSrc` and `bubbleSignal` decisions made in decode. It owns the PC register, drives the instruction-memory address, and generates the IF/ID write-enable and flush strobes. It also runs the two-word reset-vector boot sequence and, when configured, the interrupt-vector entry.

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-end PC sequencer: two-word vector boot, increment/redirect/stall, IF/ID strobes.
// Optional interrupt-vector entry is enabled by defining INTERRUPT_EN.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned RESET_VEC_ADDR = 0,
  parameter int unsigned INT_VEC_ADDR   = 2,
  parameter int unsigned FLUSH_SLOTS    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pcSrc,
  input  logic                bubbleSignal,
  input  logic [PC_WIDTH-1:0] jumpTarget,
  input  logic                isLongInstr,
  input  logic [15:0]         imemData,
  input  logic                intr,
  output logic [PC_WIDTH-1:0] imemAddr,
  output logic [PC_WIDTH-1:0] pc,
  output logic                ifIdWrite,
  output logic                ifIdFlush,
  output logic [PC_WIDTH-1:0] retPc,
  output logic                intAck
);

  typedef enum logic [2:0] {
    BOOT_HI, BOOT_LO, RUN, INT_HI, INT_LO
  } state_t;

  localparam logic [PC_WIDTH-1:0] RST_HI_A =
    PC_WIDTH'(RESET_VEC_ADDR);
  localparam logic [PC_WIDTH-1:0] RST_LO_A =
    PC_WIDTH'(RESET_VEC_ADDR + 1);
  localparam logic [PC_WIDTH-1:0] INT_HI_A =
    PC_WIDTH'(INT_VEC_ADDR);
  localparam logic [PC_WIDTH-1:0] INT_LO_A =
    PC_WIDTH'(INT_VEC_ADDR + 1);
  localparam logic [1:0] FLUSH_CNT = 2'(FLUSH_SLOTS);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] ret_q, ret_d;
  logic [1:0]          cnt_q, cnt_d;

  logic                stall, jump, take_int;
  logic [PC_WIDTH-1:0] inc;

  // Stall and jump are kept mutually exclusive: a bubble wins over a redirect.
  assign stall = bubbleSignal | (pcSrc == 2'b10);
  assign jump  = ~bubbleSignal & (pcSrc == 2'b01);
  assign inc   = {{(PC_WIDTH-2){1'b0}}, isLongInstr, ~isLongInstr};

`ifdef INTERRUPT_EN
  assign take_int = intr & ~stall & ~jump & (cnt_q == 2'd0);
`else
  logic unused_intr;
  assign unused_intr = intr;
  assign take_int    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT_HI;
      pc_q    <= '0;
      ret_q   <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    cnt_d   = (cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
    unique case (state_q)
      BOOT_HI: begin
        pc_d[31:16] = imemData;
        state_d     = BOOT_LO;
      end
      BOOT_LO: begin
        pc_d[15:0] = imemData;
        state_d    = RUN;
      end
      RUN: begin
        unique case (1'b1)
          stall: ;
          jump: begin
            pc_d  = jumpTarget;
            cnt_d = FLUSH_CNT;
          end
          take_int: begin
            ret_d   = pc_q;
            state_d = INT_HI;
          end
          default: pc_d = pc_q + inc;
        endcase
      end
      INT_HI: begin
        pc_d[31:16] = imemData;
        state_d     = INT_LO;
      end
      INT_LO: begin
        pc_d[15:0] = imemData;
        state_d    = RUN;
      end
      default: state_d = BOOT_HI;
    endcase
  end

  always_comb begin
    imemAddr  = pc_q;
    ifIdWrite = 1'b1;
    ifIdFlush = 1'b1;
    intAck    = 1'b0;
    unique case (state_q)
      BOOT_HI: imemAddr = RST_HI_A;
      BOOT_LO: imemAddr = RST_LO_A;
      RUN: begin
        ifIdWrite = ~stall;
        ifIdFlush = jump | (cnt_q != 2'd0);
      end
      INT_HI: imemAddr = INT_HI_A;
      INT_LO: begin
        imemAddr = INT_LO_A;
        intAck   = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc    = pc_q;
  assign retPc = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 4-word combinational imem model.
// Interrupt steps follow INTERRUPT_EN; otherwise intr must be ignored.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic        bubble;
  logic [31:0] jump_target;
  logic        is_long;
  logic [15:0] imem_data;
  logic        intr;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        if_id_write;
  logic        if_id_flush;
  logic [31:0] ret_pc;
  logic        int_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_WIDTH(32), .RESET_VEC_ADDR(0),
    .INT_VEC_ADDR(2), .FLUSH_SLOTS(2)
  ) dut (
    .clk(clk), .rst(rst), .pcSrc(pc_src),
    .bubbleSignal(bubble), .jumpTarget(jump_target),
    .isLongInstr(is_long), .imemData(imem_data),
    .intr(intr), .imemAddr(imem_addr), .pc(pc),
    .ifIdWrite(if_id_write), .ifIdFlush(if_id_flush),
    .retPc(ret_pc), .intAck(int_ack)
  );

  always_comb begin
    imem_data = 16'h0000;
    case (imem_addr)
      32'd1:   imem_data = 16'h0040;
      32'd3:   imem_data = 16'h0200;
      default: imem_data = 16'h0000;
    endcase
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pc_src = 2'b00; bubble = 1'b0;
    jump_target = '0; is_long = 1'b0; intr = 1'b0;
    #1;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_ret", ret_pc, 32'h0);
    check("rst_wr", 32'(if_id_write), 32'h1);
    check("rst_fl", 32'(if_id_flush), 32'h1);
    check("rst_ack", 32'(int_ack), 32'h0);

    tick();
    rst = 1'b1;
    #1;
    check("boot1_addr", imem_addr, 32'h0);
    check("boot1_fl", 32'(if_id_flush), 32'h1);
    tick();
    check("boot2_addr", imem_addr, 32'h1);
    check("boot2_fl", 32'(if_id_flush), 32'h1);
    tick();
    check("run_addr", imem_addr, 32'h40);
    check("run_pc", pc, 32'h40);
    check("run_fl", 32'(if_id_flush), 32'h0);
    check("run_wr", 32'(if_id_write), 32'h1);

    is_long = 1'b0; tick();
    check("seq1", pc, 32'h41);
    is_long = 1'b1; tick();
    check("seq2", pc, 32'h43);
    is_long = 1'b0; tick();
    check("seq3", pc, 32'h44);

    pc_src = 2'b01; jump_target = 32'h100;
    #1;
    check("jmp_fl0", 32'(if_id_flush), 32'h1);
    tick();
    pc_src = 2'b00;
    #1;
    check("jmp_addr", imem_addr, 32'h100);
    check("jmp_fl1", 32'(if_id_flush), 32'h1);
    tick();
    check("jmp_pc2", pc, 32'h101);
    check("jmp_fl2", 32'(if_id_flush), 32'h1);
    tick();
    check("jmp_fl3", 32'(if_id_flush), 32'h0);
    check("jmp_pc3", pc, 32'h102);

    bubble = 1'b1; pc_src = 2'b01; jump_target = 32'h300;
    #1;
    check("stl_wr0", 32'(if_id_write), 32'h0);
    check("stl_fl0", 32'(if_id_flush), 32'h0);
    tick();
    check("stl_pc1", pc, 32'h102);
    check("stl_wr1", 32'(if_id_write), 32'h0);
    check("stl_fl1", 32'(if_id_flush), 32'h0);
    tick();
    check("stl_pc2", pc, 32'h102);
    bubble = 1'b0; pc_src = 2'b00;
    #1;
    check("stl_wr2", 32'(if_id_write), 32'h1);
    tick();
    check("stl_resume", pc, 32'h103);

    pc_src = 2'b10;
    #1;
    check("hold_wr", 32'(if_id_write), 32'h0);
    tick();
    check("hold_pc", pc, 32'h103);
    pc_src = 2'b11; tick();
    check("rsv_inc", pc, 32'h104);

    pc_src = 2'b01; jump_target = 32'hFFFF_FFFF; tick();
    check("wrap_pre", pc, 32'hFFFF_FFFF);
    pc_src = 2'b00; is_long = 1'b1; tick();
    check("wrap", pc, 32'h1);
    is_long = 1'b0;

    pc_src = 2'b01; jump_target = 32'h50; tick();
    pc_src = 2'b10; intr = 1'b1; tick();
    pc_src = 2'b00;
    #1;
    check("int_gate_pc", pc, 32'h50);
    check("int_gate_fl", 32'(if_id_flush), 32'h1);
    pc_src = 2'b10; tick();
    pc_src = 2'b00;
    #1;
    check("int_rdy_fl", 32'(if_id_flush), 32'h0);
    check("int_rdy_ret", ret_pc, 32'h0);
    tick();
`ifdef INTERRUPT_EN
    check("ih_addr", imem_addr, 32'h2);
    check("ih_ret", ret_pc, 32'h50);
    check("ih_ack", 32'(int_ack), 32'h0);
    check("ih_fl", 32'(if_id_flush), 32'h1);
    tick();
    check("il_addr", imem_addr, 32'h3);
    check("il_ack", 32'(int_ack), 32'h1);
    intr = 1'b0;
    tick();
    check("iret_pc", pc, 32'h200);
    check("iret_addr", imem_addr, 32'h200);
    check("iret_ack", 32'(int_ack), 32'h0);
    check("iret_ret", ret_pc, 32'h50);
    intr = 1'b1; tick();
    check("ih2_addr", imem_addr, 32'h2);
`else
    check("noint_pc", pc, 32'h51);
    check("noint_ret", ret_pc, 32'h0);
    check("noint_ack", 32'(int_ack), 32'h0);
    tick();
    check("noint_pc2", pc, 32'h52);
`endif
    rst = 1'b0;
    #1;
    check("abort_addr", imem_addr, 32'h0);
    check("abort_pc", pc, 32'h0);
    check("abort_ret", ret_pc, 32'h0);
    check("abort_fl", 32'(if_id_flush), 32'h1);
    intr = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("reboot_pc", pc, 32'h40);
    check("reboot_addr", imem_addr, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
